// File: rtl/host_reg_pkg.sv
// Shared state encoding and default timing/width constants for the host
// register bus arbiter.
package host_reg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int DEF_AW        = 8;
   localparam int DEF_DW        = 16;
   localparam int DEF_SETUP_CYC = 1;
   localparam int DEF_STRB_CYC  = 2;
   localparam int DEF_HOLD_CYC  = 1;
   localparam int CNT_W         = 3;

endpackage

// File: rtl/host_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// scanning upward with wrap-around.
module rr_pick
   import host_reg_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    idx_o
);

   logic          found;
   int            j;
   logic [IW-1:0] jj;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N_REQ) j = j - N_REQ;
         jj = IW'(j);
         if (!found && req_i[jj]) begin
            found     = 1'b1;
            gnt_o[jj] = 1'b1;
            idx_o     = jj;
         end
      end
   end

endmodule

// File: rtl/host_reg_arbiter.sv
// Round-robin arbiter sharing the MAC host register bus between N_REQ
// requesters; one setup/strobe/hold sequenced access per grant.
module host_reg_arbiter
   import host_reg_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int STRB_CYC  = DEF_STRB_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [N_REQ-1:0]   req_wr_i,
   input  logic [N_REQ*AW-1:0] req_addr_i,
   input  logic [N_REQ*DW-1:0] req_wdata_i,
   output logic [N_REQ-1:0]   gnt_o,
   output logic [N_REQ-1:0]   done_o,
   output logic [DW-1:0]      rdata_o,
   output logic               csb_n_o,
   output logic               wrb_n_o,
   output logic [AW-1:0]      ca_o,
   output logic [DW-1:0]      cd_out_o,
   input  logic [DW-1:0]      cd_in_i,
   output logic               busy_o
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Counter reload values: a phase of n cycles loads n-1 and exits at zero.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] STRB_LD  = CNT_W'((STRB_CYC  > 0) ? STRB_CYC  - 1 : 0);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC  > 0) ? HOLD_CYC  - 1 : 0);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [N_REQ-1:0]       gnt_q, gnt_d;
   logic                   wr_q, wr_d;
   logic [AW-1:0]          ca_q, ca_d;
   logic [DW-1:0]          cd_q, cd_d;
   logic [DW-1:0]          cap_q, cap_d;
   logic [DW-1:0]          rdata_q, rdata_d;

   logic [N_REQ-1:0]       pick_gnt;
   logic [IW-1:0]          pick_idx;
   logic [N_REQ-1:0][AW-1:0] addr_arr;
   logic [N_REQ-1:0][DW-1:0] wdata_arr;

   assign addr_arr  = req_addr_i;
   assign wdata_arr = req_wdata_i;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      gnt_d   = gnt_q;
      wr_d    = wr_q;
      ca_d    = ca_q;
      cd_d    = cd_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               gnt_d = pick_gnt;
               idx_d = pick_idx;
               wr_d  = req_wr_i[pick_idx];
               ca_d  = addr_arr[pick_idx];
               cd_d  = wdata_arr[pick_idx];
               if (SETUP_CYC > 0) begin
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LD;
               end else begin
                  state_d = ST_STROBE;
                  cnt_d   = STRB_LD;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = STRB_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               if (!wr_q) cap_d = cd_in_i;
               if (HOLD_CYC > 0) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
                  if (!wr_q) rdata_d = cd_in_i;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               if (!wr_q) rdata_d = cap_q;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
            ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
         gnt_q   <= '0;
         wr_q    <= 1'b0;
         ca_q    <= '0;
         cd_q    <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         ca_q    <= ca_d;
         cd_q    <= cd_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from state so a reset drops CSB_n immediately.
   assign csb_n_o  = (state_q != ST_STROBE);
   assign wrb_n_o  = !((state_q == ST_STROBE) && wr_q);
   assign done_o   = (state_q == ST_DONE) ? gnt_q : '0;
   assign busy_o   = (state_q != ST_IDLE);
   assign gnt_o    = gnt_q;
   assign ca_o     = ca_q;
   assign cd_out_o = cd_q;
   assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_host_reg_arbiter.sv
// Scoreboard bench for host_reg_arbiter: stimulus queues expected Done events,
// a negedge monitor pops and compares them against the bus activity seen.
module tb_host_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req, req_wr;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  gnt, done;
   logic [15:0] rdata, cd_out, cd_in;
   logic        csb_n, wrb_n, busy;
   logic [7:0]  ca;

   logic [1:0]  b_req, b_req_wr, b_gnt, b_done;
   logic [15:0] b_req_addr, b_rdata, b_cd_out;
   logic [31:0] b_req_wdata;
   logic        b_csb_n, b_wrb_n, b_busy;
   logic [7:0]  b_ca;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int          idx;
      bit          wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          done_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   csb_lo = 0, wrb_lo = 0;
   bit   wrb_bad = 0, lat_bad = 0;

   host_reg_arbiter dut (
      .clk_i(clk), .reset_i(rst), .req_i(req), .req_wr_i(req_wr),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .gnt_o(gnt), .done_o(done),
      .rdata_o(rdata), .csb_n_o(csb_n), .wrb_n_o(wrb_n), .ca_o(ca),
      .cd_out_o(cd_out), .cd_in_i(cd_in), .busy_o(busy)
   );

   host_reg_arbiter #(.SETUP_CYC(0), .STRB_CYC(1), .HOLD_CYC(0)) dut_b (
      .clk_i(clk), .reset_i(rst), .req_i(b_req), .req_wr_i(b_req_wr),
      .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .gnt_o(b_gnt), .done_o(b_done),
      .rdata_o(b_rdata), .csb_n_o(b_csb_n), .wrb_n_o(b_wrb_n), .ca_o(b_ca),
      .cd_out_o(b_cd_out), .cd_in_i(16'h0000), .busy_o(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [15:0] d);
      req_wr[i]            = wr;
      req_addr[i*8 +: 8]   = a;
      req_wdata[i*16 +: 16] = d;
      req[i]               = 1'b1;
   endtask

   task automatic push(input int i, input bit wr, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] rd, input int dc);
      exp_t e;
      e.idx = i; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd; e.done_cyc = dc;
      exp_q.push_back(e);
   endtask

   // Monitor: bus protocol bookkeeping per access, Done compared at pop time.
   always @(negedge clk) begin
      if (rst) begin
         csb_lo <= 0; wrb_lo <= 0; wrb_bad <= 0; lat_bad <= 0;
      end else begin
         chk("busy_vs_gnt", busy, (gnt != 2'b00));
         if (gnt != 2'b00) chk("gnt_onehot", $onehot(gnt), 1);
         if (!csb_n) csb_lo <= csb_lo + 1;
         if (!wrb_n) wrb_lo <= wrb_lo + 1;
         if (!wrb_n && csb_n) wrb_bad <= 1;
         if (gnt != 2'b00 && exp_q.size() > 0)
            if (ca !== exp_q[0].addr || (exp_q[0].wr && cd_out !== exp_q[0].wdata)) lat_bad <= 1;
         if (done != 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", done, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("done_idx", done, 2'b01 << mon_e.idx);
               chk("done_cycle", cyc, mon_e.done_cyc);
               chk("rdata", rdata, mon_e.rdata);
               chk("csb_low_cycles", csb_lo, 2);
               chk("wrb_low_cycles", wrb_lo, mon_e.wr ? 2 : 0);
               chk("wrb_outside_csb", wrb_bad, 0);
               chk("ca_cd_stable", lat_bad, 0);
            end
            csb_lo <= 0; wrb_lo <= 0; wrb_bad <= 0; lat_bad <= 0;
         end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
            mon_e = exp_q.pop_front();
            chk("done_timeout", done, 2'b01 << mon_e.idx);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, csb_cnt, wrb_cnt, done_cnt, done_at;
      logic [1:0] done_val;
      rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; cd_in = 16'hDEAD;
      b_req = '0; b_req_wr = '0; b_req_addr = '0; b_req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_csb_n", csb_n, 1); chk("rst_wrb_n", wrb_n, 1);
      chk("rst_ca", ca, 0);       chk("rst_cd_out", cd_out, 0);
      chk("rst_rdata", rdata, 0); chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);   chk("rst_busy", busy, 0);
      step(1); rst = 1'b0;
      step(1);

      // single write from requester 0
      k = cyc; set_req(0, 1, 8'h12, 16'hA5A5); push(0, 1, 8'h12, 16'hA5A5, 16'h0000, k + 5);
      step(5); req = '0; step(1);

      // single read from requester 1; only the last strobe cycle's data counts
      k = cyc; set_req(1, 0, 8'h30, 16'h0000); push(1, 0, 8'h30, 16'h0000, 16'h1234, k + 5);
      step(2); cd_in = 16'h1111;
      step(1); cd_in = 16'h1234;
      step(1); cd_in = 16'hDEAD;
      step(1); req = '0; step(1);

      // contention: 0 writes, 1 reads, alternating with one IDLE between
      k = cyc; cd_in = 16'hBEEF;
      set_req(0, 1, 8'h40, 16'h0101); set_req(1, 0, 8'h41, 16'h0000);
      push(0, 1, 8'h40, 16'h0101, 16'h1234, k + 5);
      push(1, 0, 8'h41, 16'h0000, 16'hBEEF, k + 11);
      push(0, 1, 8'h40, 16'h0101, 16'hBEEF, k + 17);
      push(1, 0, 8'h41, 16'h0000, 16'hBEEF, k + 23);
      step(23); req = '0; step(1);

      // inputs changed after grant are ignored
      k = cyc; set_req(0, 1, 8'h12, 16'h5A5A); push(0, 1, 8'h12, 16'h5A5A, 16'hBEEF, k + 5);
      step(1); req_addr[7:0] = 8'h55; req_wdata[15:0] = 16'hFFFF; req_wr[0] = 1'b0;
      step(4); req = '0; step(1);

      // reset in first strobe cycle of a requester-1 access (pointer is 1 here)
      k = cyc; set_req(1, 1, 8'h66, 16'h1357);
      step(2); rst = 1'b1; req = '0;
      step(1);
      @(negedge clk);
      chk("abort_csb_n", csb_n, 1); chk("abort_gnt", gnt, 0);
      chk("abort_done", done, 0);   chk("abort_busy", busy, 0);
      chk("abort_ca", ca, 0);       chk("abort_rdata", rdata, 0);
      step(1); rst = 1'b0;
      step(3);
      k = cyc; cd_in = 16'h7777;
      set_req(0, 1, 8'h70, 16'h0A0A); set_req(1, 0, 8'h71, 16'h0000);
      push(0, 1, 8'h70, 16'h0A0A, 16'h0000, k + 5);
      push(1, 0, 8'h71, 16'h0000, 16'h7777, k + 11);
      step(11); req = '0; step(2);

      // short timing instance: SETUP=0, STRB=1, HOLD=0
      k = cyc; csb_cnt = 0; wrb_cnt = 0; done_cnt = 0; done_at = -1; done_val = '0;
      b_req_wr = 2'b01; b_req_addr = 16'h0021; b_req_wdata = 32'h0000BEAD; b_req = 2'b01;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (!b_csb_n) csb_cnt++;
         if (!b_wrb_n) wrb_cnt++;
         if (b_done != 2'b00) begin done_cnt++; done_at = cyc; done_val = b_done; end
         step(1);
         if (cyc == k + 2) b_req = '0;
      end
      chk("b_done_count", done_cnt, 1);
      chk("b_done_cycle", done_at, k + 2);
      chk("b_done_idx", done_val, 2'b01);
      chk("b_csb_low_cycles", csb_cnt, 1);
      chk("b_wrb_low_cycles", wrb_cnt, 1);
      chk("b_ca", b_ca, 8'h21);

      step(3);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
